// File: rtl/pong_pkg.sv
// Shared match-phase encoding and default game tuning for the pong match sequencer.
package pong_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_NEWGAME = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_POINT   = 3'd3,
        ST_OVER    = 3'd4
    } match_state_t;

    localparam int DEF_WIN_SCORE    = 5;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_POINT_FRAMES = 90;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Graphics-side and overlay-side signals of the match sequencer; master = sequencer.
// Plain levels and pulses, no flow control.
interface pong_match_ctrl_if
    import pong_pkg::*;
#(
    parameter int SCORE_W = 4,
    parameter int RALLY_W = 8
);
    logic               frame_tick;
    logic               start_btn;
    logic               l_win;
    logic               r_win;
    logic               hit;
    logic               gra_still;
    logic [SCORE_W-1:0] l_score;
    logic [SCORE_W-1:0] r_score;
    logic [RALLY_W-1:0] rally;
    logic [STATE_W-1:0] state;
    logic               game_over;
    logic               winner;
    logic               point_pulse;

    modport master (
        input  frame_tick, start_btn, l_win, r_win, hit,
        output gra_still, l_score, r_score, rally, state, game_over, winner, point_pulse
    );

    modport slave (
        output frame_tick, start_btn, l_win, r_win, hit,
        input  gra_still, l_score, r_score, rally, state, game_over, winner, point_pulse
    );
endinterface

// File: rtl/pong_match_ctrl_btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous button level.
// rise is valid 2 clocks after the input rises and is held off until the button is seen released after reset.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    logic       sync1;
    logic       sync2;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            fill  <= {fill[0], 1'b1};
            // Arm only once sync2 carries a real sample that shows the button released,
            // so a button held through reset release never counts as a press.
            if (fill[1] && !sync2)
                armed <= 1'b1;
        end
    end

    assign rise = sync2 & ~prev & armed;
endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: scores, rally count and game phase for two-player pong.
// All outputs registered; a win level in PLAY shows up one clock later; no backpressure.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES = DEF_POINT_FRAMES,
    parameter int CNT_W        = 7,
    parameter int RALLY_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    pong_match_ctrl_if.master bus
);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [RALLY_W-1:0] RALLY_MAX  = {RALLY_W{1'b1}};

    match_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] l_score_q, l_score_d;
    logic [SCORE_W-1:0] r_score_q, r_score_d;
    logic [SCORE_W-1:0] l_inc, r_inc;
    logic [RALLY_W-1:0] rally_q, rally_d;
    logic               winner_q, winner_d;
    logic               pulse_q, pulse_d;
    logic               gra_still_q;
    logic               game_over_q;
    logic               hit_q;
    logic               hit_rise;
    logic               start_rise;

    btn_edge u_start_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.start_btn),
        .rise  (start_rise)
    );

    // hit comes from the same-clock graphics block, so only the edge flop is needed.
    assign hit_rise = bus.hit & ~hit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_NEWGAME;
            cnt_q       <= '0;
            l_score_q   <= '0;
            r_score_q   <= '0;
            rally_q     <= '0;
            winner_q    <= 1'b0;
            pulse_q     <= 1'b0;
            gra_still_q <= 1'b1;
            game_over_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_score_q   <= l_score_d;
            r_score_q   <= r_score_d;
            rally_q     <= rally_d;
            winner_q    <= winner_d;
            pulse_q     <= pulse_d;
            gra_still_q <= (state_d != ST_PLAY);
            game_over_q <= (state_d == ST_OVER);
            hit_q       <= bus.hit;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        rally_d   = rally_q;
        winner_d  = winner_q;
        pulse_d   = 1'b0;
        l_inc     = l_score_q + SCORE_W'(1);
        r_inc     = r_score_q + SCORE_W'(1);

        case (state_q)
            ST_NEWGAME: begin
                l_score_d = '0;
                r_score_d = '0;
                rally_d   = '0;
                if (start_rise) begin
                    state_d = ST_SERVE;
                    cnt_d   = SERVE_LOAD;
                end
            end

            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt_q == '0)
                        state_d = ST_PLAY;
                    else
                        cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_PLAY: begin
                if (hit_rise && rally_q != RALLY_MAX)
                    rally_d = rally_q + RALLY_W'(1);
                // Leaving PLAY on the scoring edge is what makes a held win level count once.
                if (bus.l_win) begin
                    l_score_d = l_inc;
                    pulse_d   = 1'b1;
                    if (l_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = ST_POINT;
                        cnt_d   = POINT_LOAD;
                    end
                end else if (bus.r_win) begin
                    r_score_d = r_inc;
                    pulse_d   = 1'b1;
                    if (r_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = ST_POINT;
                        cnt_d   = POINT_LOAD;
                    end
                end
            end

            ST_POINT: begin
                if (bus.frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = ST_SERVE;
                        cnt_d   = SERVE_LOAD;
                        rally_d = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_OVER: begin
                if (start_rise) begin
                    state_d   = ST_NEWGAME;
                    l_score_d = '0;
                    r_score_d = '0;
                end
            end

            default: state_d = ST_NEWGAME;
        endcase
    end

    assign bus.gra_still   = gra_still_q;
    assign bus.l_score     = l_score_q;
    assign bus.r_score     = r_score_q;
    assign bus.rally       = rally_q;
    assign bus.state       = state_q;
    assign bus.game_over   = game_over_q;
    assign bus.winner      = winner_q;
    assign bus.point_pulse = pulse_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: scripted match with a point scoreboard checked on point_pulse.
module tb_pong_match_ctrl;
    import pong_pkg::*;

    localparam int WS   = 3;
    localparam int SW   = 4;
    localparam int SF   = 2;
    localparam int PF   = 3;
    localparam int CW   = 7;
    localparam int RW   = 8;
    localparam int RW_S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic start_btn = 1'b0;
    logic l_win = 1'b0;
    logic r_win = 1'b0;
    logic hit = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pong_match_ctrl_if #(.SCORE_W(SW), .RALLY_W(RW))   bus ();
    pong_match_ctrl_if #(.SCORE_W(SW), .RALLY_W(RW_S)) bus_s ();

    assign bus.frame_tick   = frame_tick;
    assign bus.start_btn    = start_btn;
    assign bus.l_win        = l_win;
    assign bus.r_win        = r_win;
    assign bus.hit          = hit;
    assign bus_s.frame_tick = frame_tick;
    assign bus_s.start_btn  = start_btn;
    assign bus_s.l_win      = l_win;
    assign bus_s.r_win      = r_win;
    assign bus_s.hit        = hit;

    pong_match_ctrl #(
        .WIN_SCORE(WS), .SCORE_W(SW), .SERVE_FRAMES(SF),
        .POINT_FRAMES(PF), .CNT_W(CW), .RALLY_W(RW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    pong_match_ctrl #(
        .WIN_SCORE(WS), .SCORE_W(SW), .SERVE_FRAMES(SF),
        .POINT_FRAMES(PF), .CNT_W(CW), .RALLY_W(RW_S)
    ) dut_sat (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input match_state_t st);
        chk(tag, 32'(bus.state), 32'(st));
    endtask

    function automatic logic [31:0] pk(input int l, input int r, input bit go, input bit w);
        return 32'((l << 16) | (r << 8) | (int'(go) << 1) | int'(w));
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic press();
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
    endtask

    task automatic score(input bit l, input bit r, input logic [31:0] e);
        l_win = l;
        r_win = r;
        exp_q.push_back(e);
        cyc(1);
        l_win = 1'b0;
        r_win = 1'b0;
    endtask

    task automatic serve_to_play(input string tag);
        repeat (SF) tick();
        chk_st(tag, ST_PLAY);
    endtask

    task automatic point_to_serve(input string tag);
        repeat (PF - 1) tick();
        chk_st({tag, "_dwell"}, ST_POINT);
        tick();
        chk_st({tag, "_serve"}, ST_SERVE);
    endtask

    // Every point_pulse must match the next scoreboard entry.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (rst_n && bus.point_pulse) begin
            chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("point", pk(int'(bus.l_score), int'(bus.r_score), bus.game_over,
                                bus.game_over & bus.winner), e);
            end
        end
    end

    initial begin
        cyc(2);
        chk_st("rst_state", ST_NEWGAME);
        chk("rst_gra", 32'(bus.gra_still), 32'd1);
        chk("rst_l", 32'(bus.l_score), 32'd0);
        chk("rst_r", 32'(bus.r_score), 32'd0);
        chk("rst_rally", 32'(bus.rally), 32'd0);
        chk("rst_over", 32'(bus.game_over), 32'd0);
        chk("rst_winner", 32'(bus.winner), 32'd0);
        chk("rst_pulse", 32'(bus.point_pulse), 32'd0);
        rst_n = 1'b1;
        cyc(4);

        press();
        chk_st("start_lat1", ST_NEWGAME);
        cyc(1);
        chk_st("start_lat2", ST_NEWGAME);
        cyc(1);
        chk_st("start_lat3", ST_SERVE);
        chk("serve_gra", 32'(bus.gra_still), 32'd1);
        tick();
        chk_st("serve_1tick", ST_SERVE);
        tick();
        chk_st("serve_play", ST_PLAY);
        chk("play_gra", 32'(bus.gra_still), 32'd0);

        hit = 1'b1; cyc(4);
        hit = 1'b0; cyc(2);
        hit = 1'b1; cyc(3);
        hit = 1'b0; cyc(1);
        chk("rally_2", 32'(bus.rally), 32'd2);
        repeat (3) begin
            hit = 1'b1; cyc(1);
            hit = 1'b0; cyc(1);
        end
        chk("rally_5", 32'(bus.rally), 32'd5);
        chk("rally_sat", 32'(bus_s.rally), 32'd3);

        l_win = 1'b1;
        exp_q.push_back(pk(1, 0, 1'b0, 1'b0));
        cyc(1);
        chk("lwin_score", 32'(bus.l_score), 32'd1);
        chk("lwin_pulse", 32'(bus.point_pulse), 32'd1);
        chk("lwin_gra", 32'(bus.gra_still), 32'd1);
        chk_st("lwin_state", ST_POINT);
        cyc(1);
        chk("lwin_pulse_end", 32'(bus.point_pulse), 32'd0);
        cyc(3);
        l_win = 1'b0;
        cyc(1);
        chk("lwin_once", 32'(bus.l_score), 32'd1);

        point_to_serve("pt1");
        chk("rally_clr", 32'(bus.rally), 32'd0);
        chk("rally_sat_clr", 32'(bus_s.rally), 32'd0);
        serve_to_play("play2");

        press();
        cyc(3);
        chk_st("start_in_play", ST_PLAY);

        score(1'b1, 1'b1, pk(2, 0, 1'b0, 1'b0));
        chk("both_l", 32'(bus.l_score), 32'd2);
        chk("both_r", 32'(bus.r_score), 32'd0);
        point_to_serve("pt2");
        serve_to_play("play3");

        score(1'b0, 1'b1, pk(2, 1, 1'b0, 1'b0));
        point_to_serve("pt3");
        serve_to_play("play4");

        frame_tick = 1'b1;
        r_win = 1'b1;
        exp_q.push_back(pk(2, 2, 1'b0, 1'b0));
        cyc(1);
        frame_tick = 1'b0;
        r_win = 1'b0;
        chk_st("tick_win_state", ST_POINT);
        chk("tick_win_r", 32'(bus.r_score), 32'd2);
        point_to_serve("pt4");
        serve_to_play("play5");

        score(1'b0, 1'b1, pk(2, 3, 1'b1, 1'b1));
        chk_st("over_state", ST_OVER);
        chk("over_flag", 32'(bus.game_over), 32'd1);
        chk("over_winner", 32'(bus.winner), 32'd1);
        chk("over_gra", 32'(bus.gra_still), 32'd1);
        r_win = 1'b1;
        cyc(4);
        r_win = 1'b0;
        tick();
        chk("over_frozen", 32'(bus.r_score), 32'd3);
        chk_st("over_hold", ST_OVER);

        press();
        cyc(2);
        chk_st("new_state", ST_NEWGAME);
        chk("new_l", 32'(bus.l_score), 32'd0);
        chk("new_r", 32'(bus.r_score), 32'd0);
        chk("new_over", 32'(bus.game_over), 32'd0);

        cyc(2);
        press();
        cyc(2);
        chk_st("g2_serve", ST_SERVE);
        serve_to_play("g2_play");
        score(1'b1, 1'b0, pk(1, 0, 1'b0, 1'b0));
        tick();
        chk_st("pre_reset", ST_POINT);
        start_btn = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk_st("arst_state", ST_NEWGAME);
        chk("arst_gra", 32'(bus.gra_still), 32'd1);
        chk("arst_l", 32'(bus.l_score), 32'd0);
        chk("arst_pulse", 32'(bus.point_pulse), 32'd0);
        chk("arst_over", 32'(bus.game_over), 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        chk_st("held_start", ST_NEWGAME);
        start_btn = 1'b0;
        cyc(4);
        chk_st("release_start", ST_NEWGAME);
        press();
        cyc(2);
        chk_st("start_after_release", ST_SERVE);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
